// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter and forwarding stage for the 32x32 register file.
//   Two requesters share the single register-file write port. Requester 0 is
//   ALU/immediate write-back and requester 1 is load/memory write-back.
//   Arbitration is round-robin through a 1-bit priority pointer. The winner is
//   registered onto the WE3/A3/WD3 triple. The in-flight write is forwarded
//   to both read ports.
//
// Ports
//   i_clk, i_rst_n            clock; synchronous active-low reset
//   i_req{0,1}_valid/addr/data write requests (valid/ready handshake)
//   o_req{0,1}_ready          grant, combinational from both valids and priority
//   o_we3, o_a3, o_wd3        registered register-file write port
//   i_a1, i_a2                read addresses (same nets as the register file)
//   i_rf_rd1, i_rf_rd2        raw register-file read data
//   o_rd1, o_rd2              forwarded read data
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_req1_ready,
    output logic                  o_we3,
    output logic [ADDR_WIDTH-1:0] o_a3,
    output logic [DATA_WIDTH-1:0] o_wd3,
    input  logic [ADDR_WIDTH-1:0] i_a1,
    input  logic [ADDR_WIDTH-1:0] i_a2,
    input  logic [DATA_WIDTH-1:0] i_rf_rd1,
    input  logic [DATA_WIDTH-1:0] i_rf_rd2,
    output logic [DATA_WIDTH-1:0] o_rd1,
    output logic [DATA_WIDTH-1:0] o_rd2
);

    logic                  r_pri;  // requester that wins a tie
    logic                  r_we3;
    logic [ADDR_WIDTH-1:0] r_a3;
    logic [DATA_WIDTH-1:0] r_wd3;

    logic w_gnt0;
    logic w_gnt1;

    // Grants are suppressed during reset so nothing is accepted and then lost.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_rst_n) begin
            if (i_req0_valid && i_req1_valid) begin
                w_gnt0 = ~r_pri;
                w_gnt1 = r_pri;
            end else begin
                w_gnt0 = i_req0_valid;
                w_gnt1 = i_req1_valid;
            end
        end
    end

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    // A write to x0 completes its handshake but never raises WE3.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pri <= 1'b0;
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_gnt0) begin
            r_pri <= 1'b1;
            r_we3 <= (i_req0_addr != '0);
            r_a3  <= i_req0_addr;
            r_wd3 <= i_req0_data;
        end else if (w_gnt1) begin
            r_pri <= 1'b0;
            r_we3 <= (i_req1_addr != '0);
            r_a3  <= i_req1_addr;
            r_wd3 <= i_req1_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign o_we3 = r_we3;
    assign o_a3  = r_a3;
    assign o_wd3 = r_wd3;

    // x0 reads as zero first. WE3 is never set with A3 == 0, so the order of
    // the two checks only matters for clarity.
    always_comb begin
        if (i_a1 == '0) begin
            o_rd1 = '0;
        end else if (r_we3 && (i_a1 == r_a3)) begin
            o_rd1 = r_wd3;
        end else begin
            o_rd1 = i_rf_rd1;
        end
    end

    always_comb begin
        if (i_a2 == '0) begin
            o_rd2 = '0;
        end else if (r_we3 && (i_a2 == r_a3)) begin
            o_rd2 = r_wd3;
        end else begin
            o_rd2 = i_rf_rd2;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        v0, v1;
    logic [4:0]  a0, a1w;
    logic [31:0] d0, d1;
    logic        rdy0, rdy1;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  ra1, ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rd1, rd2;

    logic [31:0] rf [32];
    wr_t         exp_q[$];
    logic        m_pri;
    logic        s_rdy0, s_rdy1;
    int          n_cmp;
    int          n_err;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (v0),
        .i_req0_addr  (a0),
        .i_req0_data  (d0),
        .o_req0_ready (rdy0),
        .i_req1_valid (v1),
        .i_req1_addr  (a1w),
        .i_req1_data  (d1),
        .o_req1_ready (rdy1),
        .o_we3        (we3),
        .o_a3         (a3),
        .o_wd3        (wd3),
        .i_a1         (ra1),
        .i_a2         (ra2),
        .i_rf_rd1     (rf_rd1),
        .i_rf_rd2     (rf_rd2),
        .o_rd1        (rd1),
        .o_rd2        (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model fed by the DUT write port.
    always @(posedge clk) begin
        if (we3) rf[a3] <= wd3;
    end
    assign rf_rd1 = rf[ra1];
    assign rf_rd2 = rf[ra2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic apply(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                         input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
        v0 = iv0; a0 = ia0; d0 = id0;
        v1 = iv1; a1w = ia1; d1 = id1;
    endtask

    // Reference arbiter: returns {gnt1, gnt0} and pushes the expected write.
    task automatic predict(output logic [1:0] g);
        wr_t e;
        g = 2'b00;
        if (rst_n) begin
            if (v0 && v1) g = m_pri ? 2'b10 : 2'b01;
            else          g = {v1, v0};
        end else begin
            m_pri = 1'b0;
        end
        if (g == 2'b01) begin
            e.we = (a0 != 5'd0); e.a = a0; e.d = d0;
            exp_q.push_back(e);
            m_pri = 1'b1;
        end else if (g == 2'b10) begin
            e.we = (a1w != 5'd0); e.a = a1w; e.d = d1;
            exp_q.push_back(e);
            m_pri = 1'b0;
        end
    endtask

    // Sample combinational grants mid-cycle, then advance past the edge.
    task automatic tick();
        @(negedge clk);
        s_rdy0 = rdy0;
        s_rdy1 = rdy1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        for (int i = 0; i < 2; i++) begin
            exp_q.delete();
            m_pri = 1'b0;
            tick();
            n_cmp++;
            if ({s_rdy1, s_rdy0} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_ready: got %b want 00", {s_rdy1, s_rdy0});
            end
            n_cmp++;
            if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin
                n_err++;
                $display("FAIL reset_state: got we3=%b a3=%0d wd3=%h want 0/0/0", we3, a3, wd3);
            end
        end
        apply(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic [1:0] g;
        wr_t        e;
        ra1 = 5'd5; ra2 = 5'd0;
        apply(1, 5'd5, 32'h11, 0, 0, 0);
        predict(g);
        tick();
        n_cmp++;
        if ({s_rdy1, s_rdy0} !== g) begin
            n_err++;
            $display("FAIL single_ready: got %b want %b", {s_rdy1, s_rdy0}, g);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (we3 !== e.we || a3 !== e.a || wd3 !== e.d) begin
            n_err++;
            $display("FAIL single_wr: got %b/%0d/%h want %b/%0d/%h", we3, a3, wd3, e.we, e.a, e.d);
        end
        apply(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rd1 !== 32'h11) begin
            n_err++;
            $display("FAIL single_forward: got %h want 00000011 (rf stale=%h)", rd1, rf_rd1);
        end
        n_cmp++;
        if (rd2 !== 32'd0) begin
            n_err++;
            $display("FAIL single_x0_read: got %h want 0", rd2);
        end
        predict(g);
        tick();
        n_cmp++;
        if (we3 !== 1'b0 || rd1 !== 32'h11) begin
            n_err++;
            $display("FAIL single_after: got we3=%b rd1=%h want 0/00000011", we3, rd1);
        end
    endtask

    task automatic test_x0_write();
        logic [1:0] g;
        wr_t        e;
        ra1 = 5'd0;
        apply(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        predict(g);
        tick();
        n_cmp++;
        if ({s_rdy1, s_rdy0} !== 2'b10) begin
            n_err++;
            $display("FAIL x0_ready: got %b want 10", {s_rdy1, s_rdy0});
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (we3 !== e.we || a3 !== e.a || wd3 !== e.d) begin
            n_err++;
            $display("FAIL x0_wr: got %b/%0d/%h want %b/%0d/%h", we3, a3, wd3, e.we, e.a, e.d);
        end
        n_cmp++;
        if (rd1 !== 32'd0) begin
            n_err++;
            $display("FAIL x0_read: got %h want 0", rd1);
        end
        apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_contention();
        logic [1:0] g;
        logic [1:0] want [4];
        wr_t        e;
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            apply(1, 5'd1, 32'hA0, 1, 5'd2, 32'hB0);
            predict(g);
            tick();
            n_cmp++;
            if ({s_rdy1, s_rdy0} !== want[i] || g !== want[i]) begin
                n_err++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i, {s_rdy1, s_rdy0},
                         want[i]);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (we3 !== e.we || a3 !== e.a || wd3 !== e.d) begin
                n_err++;
                $display("FAIL contention_wr[%0d]: got %b/%0d/%h want %b/%0d/%h", i, we3, a3,
                         wd3, e.we, e.a, e.d);
            end
        end
        apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_same_address();
        logic [1:0] g;
        wr_t        e;
        // Give requester 1 priority by letting requester 0 win a solo write.
        apply(1, 5'd3, 32'h33, 0, 0, 0);
        predict(g);
        tick();
        void'(exp_q.pop_front());
        ra1 = 5'd9;
        for (int i = 0; i < 2; i++) begin
            apply(1, 5'd9, 32'hA, (i == 0), 5'd9, 32'hB);
            predict(g);
            tick();
            n_cmp++;
            if ({s_rdy1, s_rdy0} !== g) begin
                n_err++;
                $display("FAIL same_grant[%0d]: got %b want %b", i, {s_rdy1, s_rdy0}, g);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (we3 !== e.we || a3 !== e.a || wd3 !== e.d) begin
                n_err++;
                $display("FAIL same_wr[%0d]: got %b/%0d/%h want %b/%0d/%h", i, we3, a3, wd3,
                         e.we, e.a, e.d);
            end
            n_cmp++;
            if (rd1 !== ((i == 0) ? 32'hB : 32'hA)) begin
                n_err++;
                $display("FAIL same_forward[%0d]: got %h want %h", i, rd1,
                         (i == 0) ? 32'hB : 32'hA);
            end
        end
        apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_idle_hold();
        logic [1:0] g;
        wr_t        e;
        ra1 = 5'd9; ra2 = 5'd2;
        for (int i = 0; i < 3; i++) begin
            predict(g);
            tick();
            n_cmp++;
            if (we3 !== 1'b0 || a3 !== 5'd9 || wd3 !== 32'hA) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got %b/%0d/%h want 0/9/0000000a", i, we3, a3,
                         wd3);
            end
            n_cmp++;
            if (rd1 !== 32'hA || rd2 !== 32'hB0) begin
                n_err++;
                $display("FAIL idle_pass[%0d]: got %h/%h want 0000000a/000000b0", i, rd1, rd2);
            end
        end
        // Last grant went to requester 0, so requester 1 must win the next tie.
        apply(1, 5'd4, 32'h4, 1, 5'd6, 32'h6);
        predict(g);
        tick();
        n_cmp++;
        if ({s_rdy1, s_rdy0} !== 2'b10) begin
            n_err++;
            $display("FAIL idle_pri: got %b want 10", {s_rdy1, s_rdy0});
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (we3 !== e.we || a3 !== e.a || wd3 !== e.d) begin
            n_err++;
            $display("FAIL idle_pri_wr: got %b/%0d/%h want %b/%0d/%h", we3, a3, wd3, e.we, e.a,
                     e.d);
        end
        apply(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        wr_t        e;
        apply(1, 5'd7, 32'h77, 0, 0, 0);
        predict(g);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (we3 !== 1'b1 || a3 !== e.a || wd3 !== e.d) begin
            n_err++;
            $display("FAIL rstmid_pre: got %b/%0d/%h want 1/%0d/%h", we3, a3, wd3, e.a, e.d);
        end
        rst_n = 1'b0;
        apply(1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
        predict(g);
        tick();
        n_cmp++;
        if ({s_rdy1, s_rdy0} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_ready: got %b want 00", {s_rdy1, s_rdy0});
        end
        n_cmp++;
        if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_state: got %b/%0d/%h want 0/0/0", we3, a3, wd3);
        end
        rst_n = 1'b1;
        predict(g);
        tick();
        n_cmp++;
        if ({s_rdy1, s_rdy0} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_release: got %b want 01", {s_rdy1, s_rdy0});
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (we3 !== e.we || a3 !== e.a || wd3 !== e.d) begin
            n_err++;
            $display("FAIL rstmid_wr: got %b/%0d/%h want %b/%0d/%h", we3, a3, wd3, e.we, e.a,
                     e.d);
        end
        apply(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_pri = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst_n = 1'b0;
        ra1 = 5'd0;
        ra2 = 5'd0;
        apply(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_write();
        test_x0_write();
        test_contention();
        test_same_address();
        test_idle_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
